plot_monitor: RTL

PLOT_MONITOR -- requirements
Module: plot_monitor

---
 rtl/plot_monitor.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/plot_monitor.sv
// plot_monitor -- gathers statistics about a stream of pixel writes.
//
// A capture begins with the first in-range plot. It ends once IDLE_TIMEOUT
// consecutive cycles pass with plot low. During a capture the block keeps
// the pixel count (saturating at 32767), the bounding box and the last
// colour. Out-of-range plots only set a sticky error flag. The clear input
// and reset_n both return everything to the reset state.
//
// Ports:
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   x, y         pixel coordinates (8 / 7 bits)
//   colour       pixel colour (3 bits)
//   plot         write strobe, sampled on every rising edge
//   clear        synchronous restart request; takes priority over plot
//   pixel_count  accepted in-range pixels in the current capture
//   min_x/max_x  x extent of the accepted pixels
//   min_y/max_y  y extent of the accepted pixels
//   last_colour  colour of the most recently accepted pixel
//   range_err    sticky flag: an out-of-range pixel was seen
//   busy         high while capturing
//   frame_done   one-cycle pulse after a capture ends
module plot_monitor #(
  parameter int IDLE_TIMEOUT = 16,
  parameter int MAX_X        = 159,
  parameter int MAX_Y        = 119
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  x,
  input  logic [6:0]  y,
  input  logic [2:0]  colour,
  input  logic        plot,
  input  logic        clear,
  output logic [14:0] pixel_count,
  output logic [7:0]  min_x,
  output logic [7:0]  max_x,
  output logic [6:0]  min_y,
  output logic [6:0]  max_y,
  output logic [2:0]  last_colour,
  output logic        range_err,
  output logic        busy,
  output logic        frame_done
);

  localparam logic [7:0]  MAX_X_L   = 8'(MAX_X);
  localparam logic [6:0]  MAX_Y_L   = 7'(MAX_Y);
  localparam logic [7:0]  IDLE_LAST = 8'(IDLE_TIMEOUT - 1);
  localparam logic [14:0] COUNT_MAX = 15'h7FFF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [7:0]  idle_reg, idle_next;
  logic [14:0] count_next;
  logic [7:0]  min_x_next, max_x_next;
  logic [6:0]  min_y_next, max_y_next;
  logic [2:0]  colour_next;
  logic        err_next, busy_next, done_next;
  logic        in_range;

  assign in_range = (x <= MAX_X_L) && (y <= MAX_Y_L);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      idle_reg    <= 8'd0;
      pixel_count <= 15'd0;
      min_x       <= 8'hFF;
      max_x       <= 8'd0;
      min_y       <= 7'h7F;
      max_y       <= 7'd0;
      last_colour <= 3'd0;
      range_err   <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      idle_reg    <= idle_next;
      pixel_count <= count_next;
      min_x       <= min_x_next;
      max_x       <= max_x_next;
      min_y       <= min_y_next;
      max_y       <= max_y_next;
      last_colour <= colour_next;
      range_err   <= err_next;
      busy        <= busy_next;
      frame_done  <= done_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    idle_next   = idle_reg;
    count_next  = pixel_count;
    min_x_next  = min_x;
    max_x_next  = max_x;
    min_y_next  = min_y;
    max_y_next  = max_y;
    colour_next = last_colour;
    err_next    = range_err;
    done_next   = 1'b0;

    if (clear) begin
      // The pixel presented with clear is dropped.
      state_next  = IDLE;
      idle_next   = 8'd0;
      count_next  = 15'd0;
      min_x_next  = 8'hFF;
      max_x_next  = 8'd0;
      min_y_next  = 7'h7F;
      max_y_next  = 7'd0;
      colour_next = 3'd0;
      err_next    = 1'b0;
    end else if (plot && !in_range) begin
      err_next = 1'b1;
      // A rejected write still counts as activity, so it restarts the
      // idle count.
      if (state_reg == CAPTURE) begin
        idle_next = 8'd0;
      end
    end else if (plot) begin
      if (state_reg == CAPTURE) begin
        if (pixel_count != COUNT_MAX) begin
          count_next = pixel_count + 15'd1;
        end
        if (x < min_x) min_x_next = x;
        if (x > max_x) max_x_next = x;
        if (y < min_y) min_y_next = y;
        if (y > max_y) max_y_next = y;
      end else begin
        // Coming from IDLE or DONE: start a new capture. range_err is
        // kept as it is.
        state_next = CAPTURE;
        count_next = 15'd1;
        min_x_next = x;
        max_x_next = x;
        min_y_next = y;
        max_y_next = y;
      end
      colour_next = colour;
      idle_next   = 8'd0;
    end else if (state_reg == CAPTURE) begin
      // idle_reg holds the number of low samples already taken. When it
      // equals IDLE_TIMEOUT-1, this sample is the last one.
      if (idle_reg == IDLE_LAST) begin
        state_next = DONE;
        done_next  = 1'b1;
        idle_next  = 8'd0;
      end else begin
        idle_next = idle_reg + 8'd1;
      end
    end

    busy_next = (state_next == CAPTURE);
  end

endmodule
